// File: rtl/stream_fifo_dut_if.sv
// Valid/ready handshake bundle for stream_fifo_dut: upstream write side and downstream read side.
interface stream_fifo_dut_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] o_data;

  modport master (
    output i_valid, i_data, o_ready,
    input  i_ready, o_valid, o_data
  );

  modport slave (
    input  i_valid, i_data, o_ready,
    output i_ready, o_valid, o_data
  );
endinterface

// File: rtl/stream_fifo_dut.sv
// Valid/ready FIFO with registered outputs, wide transfer counters and a wide
// accumulator of accepted input data.
module stream_fifo_dut #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int SUM_WIDTH  = 128
) (
  input  logic                     clock,
  input  logic                     reset,
  stream_fifo_dut_if.slave         s,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [63:0]              in_xfers,
  output logic [63:0]              out_xfers,
  output logic [SUM_WIDTH-1:0]     data_sum
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push;
  logic                  pop;

  // Accumulator step: zero-extend the beat and let the sum wrap at SUM_WIDTH.
  function automatic logic [SUM_WIDTH-1:0] sum_add(
    input logic [SUM_WIDTH-1:0]  acc,
    input logic [DATA_WIDTH-1:0] d
  );
    return acc + SUM_WIDTH'(d);
  endfunction

  assign s.i_ready = (count != CW'(DEPTH));
  assign s.o_valid = (count != '0);
  assign s.o_data  = mem[rd_ptr];

  assign push = s.i_valid & s.i_ready;
  assign pop  = s.o_valid & s.o_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      in_xfers  <= '0;
      out_xfers <= '0;
      data_sum  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      // Handshakes in a flush cycle are dropped; storage and statistics survive.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s.i_data;
        wr_ptr      <= wr_ptr + AW'(1);
        in_xfers    <= in_xfers + 64'd1;
        data_sum    <= sum_add(data_sum, s.i_data);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        out_xfers <= out_xfers + 64'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_stream_fifo_dut.sv
// Scoreboard bench for stream_fifo_dut: a reference occupancy/queue model runs
// alongside the DUT and each scenario task compares outputs against it.
module tb_stream_fifo_dut;
  logic clock;
  logic reset;
  logic flush;
  logic [2:0]   count;
  logic [63:0]  in_xfers;
  logic [63:0]  out_xfers;
  logic [127:0] data_sum;

  logic [2:0]   count2;
  logic [63:0]  in_xfers2;
  logic [63:0]  out_xfers2;
  logic [7:0]   data_sum2;

  int checks;
  int failures;

  logic [7:0]   sb[$];
  int           mcount;
  logic [63:0]  m_in;
  logic [63:0]  m_out;
  logic [127:0] m_sum;

  stream_fifo_dut_if #(.DATA_WIDTH(8)) intf ();
  stream_fifo_dut_if #(.DATA_WIDTH(8)) intf2 ();

  stream_fifo_dut #(.DATA_WIDTH(8), .DEPTH(4), .SUM_WIDTH(128)) dut (
    .clock(clock), .reset(reset), .s(intf.slave), .flush(flush),
    .count(count), .in_xfers(in_xfers), .out_xfers(out_xfers), .data_sum(data_sum)
  );

  stream_fifo_dut #(.DATA_WIDTH(8), .DEPTH(4), .SUM_WIDTH(8)) dut2 (
    .clock(clock), .reset(reset), .s(intf2.slave), .flush(1'b0),
    .count(count2), .in_xfers(in_xfers2), .out_xfers(out_xfers2), .data_sum(data_sum2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock cycle of stimulus, entered and left at a falling edge.
  task automatic cycle(input logic iv, input logic [7:0] d, input logic ordy, input logic fl,
                       output logic popped, output logic [7:0] pdata, output logic [7:0] exp);
    logic mpush, mpop;
    intf.i_valid = iv;
    intf.i_data  = d;
    intf.o_ready = ordy;
    flush        = fl;
    mpush  = iv && (mcount != 4);
    mpop   = ordy && (mcount != 0);
    popped = mpop && !fl;
    pdata  = intf.o_data;
    exp    = 8'h00;
    @(posedge clock);
    #1;
    if (fl) begin
      mcount = 0;
      sb.delete();
    end else begin
      if (mpop) begin
        exp = sb.pop_front();
        m_out = m_out + 64'd1;
      end
      if (mpush) begin
        sb.push_back(d);
        m_in  = m_in + 64'd1;
        m_sum = m_sum + 128'(d);
      end
      mcount = mcount + (mpush ? 1 : 0) - (mpop ? 1 : 0);
    end
    @(negedge clock);
    intf.i_valid = 1'b0;
    intf.o_ready = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b0;
    repeat (cycles) @(posedge clock);
    #1;
    sb.delete();
    mcount = 0;
    m_in   = '0;
    m_out  = '0;
    m_sum  = '0;
    @(negedge clock);
    reset = 1'b1;
    intf.i_valid = 1'b0;
    intf.o_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(2);
    checks++; if (intf.i_ready !== 1'b1) begin failures++; $display("FAIL reset_i_ready got=%b want=1", intf.i_ready); end
    checks++; if (intf.o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid got=%b want=0", intf.o_valid); end
    checks++; if (intf.o_data !== 8'h00) begin failures++; $display("FAIL reset_o_data got=%h want=00", intf.o_data); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", count); end
    checks++; if (in_xfers !== 64'd0 || out_xfers !== 64'd0) begin failures++; $display("FAIL reset_xfers got=%0d/%0d want=0/0", in_xfers, out_xfers); end
    checks++; if (data_sum !== 128'd0) begin failures++; $display("FAIL reset_data_sum got=%h want=0", data_sum); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (dut.mem[i] !== 8'h00) begin failures++; $display("FAIL reset_mem%0d got=%h want=00", i, dut.mem[i]); end
    end
  endtask

  task automatic test_fill();
    logic p; logic [7:0] pd, ex;
    for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i * 8'h11), 1'b0, 1'b0, p, pd, ex);
    checks++; if (count !== 3'(mcount)) begin failures++; $display("FAIL fill_count got=%0d want=%0d", count, mcount); end
    checks++; if (intf.i_ready !== 1'b0) begin failures++; $display("FAIL fill_i_ready got=%b want=0", intf.i_ready); end
    checks++; if (intf.o_data !== 8'h11) begin failures++; $display("FAIL fill_o_data got=%h want=11", intf.o_data); end
    cycle(1'b1, 8'h55, 1'b0, 1'b0, p, pd, ex);
    checks++; if (in_xfers !== m_in || m_in !== 64'd4) begin failures++; $display("FAIL fill_overflow_in_xfers got=%0d want=4", in_xfers); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_overflow_count got=%0d want=4", count); end
  endtask

  task automatic test_full_pop_drain();
    logic p; logic [7:0] pd, ex;
    cycle(1'b1, 8'h55, 1'b1, 1'b0, p, pd, ex);
    checks++; if (!p || pd !== 8'h11 || ex !== 8'h11) begin failures++; $display("FAIL full_pop got=%h want=11", pd); end
    checks++; if (count !== 3'd3 || intf.i_ready !== 1'b1) begin failures++; $display("FAIL full_pop_state count=%0d i_ready=%b want=3/1", count, intf.i_ready); end
    cycle(1'b1, 8'h55, 1'b0, 1'b0, p, pd, ex);
    for (int i = 0; i < 4; i++) begin
      checks++; if (intf.o_valid !== 1'b1) begin failures++; $display("FAIL drain_o_valid%0d got=%b want=1", i, intf.o_valid); end
      cycle(1'b0, 8'h00, 1'b1, 1'b0, p, pd, ex);
      checks++; if (pd !== ex) begin failures++; $display("FAIL drain_data%0d got=%h want=%h", i, pd, ex); end
    end
    checks++; if (ex !== 8'h55) begin failures++; $display("FAIL drain_last got=%h want=55", ex); end
    checks++; if (out_xfers !== m_out || m_out !== 64'd5) begin failures++; $display("FAIL drain_out_xfers got=%0d want=5", out_xfers); end
    checks++; if (dut.wr_ptr !== 2'd1) begin failures++; $display("FAIL drain_wr_ptr got=%0d want=1", dut.wr_ptr); end
    checks++; if (intf.o_valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL drain_empty o_valid=%b count=%0d want=0/0", intf.o_valid, count); end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, p, pd, ex);
    checks++; if (out_xfers !== 64'd5) begin failures++; $display("FAIL empty_pop_ignored got=%0d want=5", out_xfers); end
  endtask

  task automatic test_stream();
    logic p; logic [7:0] pd, ex;
    logic [63:0] in0, out0;
    cycle(1'b1, 8'hC1, 1'b0, 1'b0, p, pd, ex);
    cycle(1'b1, 8'hC2, 1'b0, 1'b0, p, pd, ex);
    in0 = in_xfers;
    out0 = out_xfers;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0, p, pd, ex);
      checks++; if (!p || pd !== ex) begin failures++; $display("FAIL stream_data%0d got=%h want=%h", i, pd, ex); end
      checks++; if (count !== 3'd2) begin failures++; $display("FAIL stream_count%0d got=%0d want=2", i, count); end
    end
    checks++; if (in_xfers !== in0 + 64'd10 || out_xfers !== out0 + 64'd10) begin failures++; $display("FAIL stream_xfers got=%0d/%0d want=%0d/%0d", in_xfers, out_xfers, in0 + 64'd10, out0 + 64'd10); end
    checks++; if (data_sum !== m_sum) begin failures++; $display("FAIL stream_data_sum got=%h want=%h", data_sum, m_sum); end
  endtask

  task automatic test_sum_wrap();
    intf2.i_valid = 1'b1;
    intf2.i_data  = 8'hFF;
    @(posedge clock); #1;
    intf2.i_data  = 8'h02;
    @(posedge clock); #1;
    intf2.i_valid = 1'b0;
    @(negedge clock);
    checks++; if (data_sum2 !== 8'h01) begin failures++; $display("FAIL sum_wrap got=%h want=01", data_sum2); end
    checks++; if (in_xfers2 !== 64'd2 || count2 !== 3'd2) begin failures++; $display("FAIL sum_wrap_xfers got=%0d count=%0d want=2/2", in_xfers2, count2); end
  endtask

  task automatic test_flush();
    logic p; logic [7:0] pd, ex;
    logic [63:0] in0;
    logic [127:0] sum0;
    cycle(1'b1, 8'hD1, 1'b0, 1'b0, p, pd, ex);
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL flush_pre_count got=%0d want=3", count); end
    in0 = m_in;
    sum0 = m_sum;
    cycle(1'b1, 8'hAA, 1'b1, 1'b1, p, pd, ex);
    checks++; if (count !== 3'd0 || intf.o_valid !== 1'b0) begin failures++; $display("FAIL flush_state count=%0d o_valid=%b want=0/0", count, intf.o_valid); end
    checks++; if (in_xfers !== in0 || data_sum !== sum0) begin failures++; $display("FAIL flush_stats in=%0d sum=%h want=%0d/%h", in_xfers, data_sum, in0, sum0); end
    cycle(1'b1, 8'h3C, 1'b0, 1'b0, p, pd, ex);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, p, pd, ex);
    checks++; if (!p || pd !== 8'h3C || ex !== 8'h3C) begin failures++; $display("FAIL flush_after got=%h want=3C", pd); end
  endtask

  task automatic test_reset_mid();
    logic p; logic [7:0] pd, ex;
    cycle(1'b1, 8'hE1, 1'b0, 1'b0, p, pd, ex);
    cycle(1'b1, 8'hE2, 1'b0, 1'b0, p, pd, ex);
    intf.i_valid = 1'b1;
    intf.i_data  = 8'hE3;
    intf.o_ready = 1'b1;
    apply_reset(1);
    checks++; if (count !== 3'd0 || intf.o_valid !== 1'b0 || intf.i_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_state count=%0d o_valid=%b i_ready=%b want=0/0/1", count, intf.o_valid, intf.i_ready); end
    checks++; if (in_xfers !== 64'd0 || out_xfers !== 64'd0 || data_sum !== 128'd0 || intf.o_data !== 8'h00) begin failures++; $display("FAIL mid_reset_stats in=%0d out=%0d sum=%h o_data=%h want=0", in_xfers, out_xfers, data_sum, intf.o_data); end
    cycle(1'b1, 8'h5A, 1'b0, 1'b0, p, pd, ex);
    checks++; if (count !== 3'd1 || intf.o_data !== 8'h5A || in_xfers !== 64'd1) begin failures++; $display("FAIL mid_reset_push count=%0d o_data=%h in=%0d want=1/5A/1", count, intf.o_data, in_xfers); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    flush = 1'b0;
    intf.i_valid = 1'b0;
    intf.i_data = 8'h00;
    intf.o_ready = 1'b0;
    intf2.i_valid = 1'b0;
    intf2.i_data = 8'h00;
    intf2.o_ready = 1'b0;
    mcount = 0;
    m_in = '0;
    m_out = '0;
    m_sum = '0;
    @(negedge clock);
    test_reset();
    test_fill();
    test_full_pop_drain();
    test_stream();
    test_sum_wrap();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
